// File: rtl/cgra_pkg.sv
// Shared definitions for the single-tile CGRA: widths, opcodes, config map and defaults.
package cgra_pkg;

  localparam int W      = 16;
  localparam int CFG_AW = 32;
  localparam int CFG_DW = 32;

  typedef enum logic [3:0] {
    OP_PASSA = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_MUL   = 4'd3,
    OP_SHL   = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7
  } op_e;

  localparam logic [CFG_AW-1:0] ADDR_OP    = 32'h1;
  localparam logic [CFG_AW-1:0] ADDR_SRC   = 32'h2;
  localparam logic [CFG_AW-1:0] ADDR_CONST = 32'h3;
  localparam logic [CFG_AW-1:0] ADDR_OREG  = 32'h4;

  // Power-up configuration computes out = in_S2 * 2.
  localparam logic [3:0]   DEF_OP    = OP_MUL;
  localparam logic [1:0]   DEF_SRCA  = 2'd2;
  localparam logic [2:0]   DEF_SRCB  = 3'd4;
  localparam logic [W-1:0] DEF_CONST = 16'd2;
  localparam logic         DEF_OREG  = 1'b0;

endpackage

// File: rtl/cgra_pe.sv
// Combinational processing element: one ALU operation on two W-bit operands, modulo 2^W.
module cgra_pe
  import cgra_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic [W-1:0] res
);

  // NOTE: every variable written in always_comb gets a value before any branch, so no latch is inferred.
  always_comb begin
    res = a;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_MUL:  res = a * b;
      OP_SHL:  res = a << b[3:0];
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      default: res = a;
    endcase
  end

endmodule

// File: rtl/cgra_top.sv
// Single-tile CGRA top: pad packing, config registers, operand muxes, PE and optional output register.
module cgra_top
  import cgra_pkg::*;
(
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [CFG_AW-1:0] config_addr_in,
  input  logic [CFG_DW-1:0] config_data_in,
  input  logic pad_S0_T0_in, pad_S0_T1_in, pad_S0_T2_in, pad_S0_T3_in,
  input  logic pad_S0_T4_in, pad_S0_T5_in, pad_S0_T6_in, pad_S0_T7_in,
  input  logic pad_S0_T8_in, pad_S0_T9_in, pad_S0_T10_in, pad_S0_T11_in,
  input  logic pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in,
  input  logic pad_S1_T0_in, pad_S1_T1_in, pad_S1_T2_in, pad_S1_T3_in,
  input  logic pad_S1_T4_in, pad_S1_T5_in, pad_S1_T6_in, pad_S1_T7_in,
  input  logic pad_S1_T8_in, pad_S1_T9_in, pad_S1_T10_in, pad_S1_T11_in,
  input  logic pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in,
  input  logic pad_S2_T0_in, pad_S2_T1_in, pad_S2_T2_in, pad_S2_T3_in,
  input  logic pad_S2_T4_in, pad_S2_T5_in, pad_S2_T6_in, pad_S2_T7_in,
  input  logic pad_S2_T8_in, pad_S2_T9_in, pad_S2_T10_in, pad_S2_T11_in,
  input  logic pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in,
  input  logic pad_S3_T0_in, pad_S3_T1_in, pad_S3_T2_in, pad_S3_T3_in,
  input  logic pad_S3_T4_in, pad_S3_T5_in, pad_S3_T6_in, pad_S3_T7_in,
  input  logic pad_S3_T8_in, pad_S3_T9_in, pad_S3_T10_in, pad_S3_T11_in,
  input  logic pad_S3_T12_in, pad_S3_T13_in, pad_S3_T14_in, pad_S3_T15_in,
  output logic pad_S0_T0_out, pad_S0_T1_out, pad_S0_T2_out, pad_S0_T3_out,
  output logic pad_S0_T4_out, pad_S0_T5_out, pad_S0_T6_out, pad_S0_T7_out,
  output logic pad_S0_T8_out, pad_S0_T9_out, pad_S0_T10_out, pad_S0_T11_out,
  output logic pad_S0_T12_out, pad_S0_T13_out, pad_S0_T14_out, pad_S0_T15_out,
  input  logic              tdi,
  input  logic              tms,
  input  logic              tck,
  input  logic              trst_n,
  output logic              tdo
);

  logic [W-1:0] side [4];
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] res;
  logic [W-1:0] out_q;
  logic [W-1:0] out_word;
  logic         unused;

  // NOTE: declaration initialisers give the default configuration at power-up with no reset; the async reset restores the same values.
  logic [3:0]   op_q    = DEF_OP;
  logic [1:0]   srca_q  = DEF_SRCA;
  logic [2:0]   srcb_q  = DEF_SRCB;
  logic [W-1:0] const_q = DEF_CONST;
  logic         oreg_q  = DEF_OREG;

  // Track T0 is the MSB of every side word.
  assign side[0] = {pad_S0_T0_in, pad_S0_T1_in, pad_S0_T2_in, pad_S0_T3_in,
                    pad_S0_T4_in, pad_S0_T5_in, pad_S0_T6_in, pad_S0_T7_in,
                    pad_S0_T8_in, pad_S0_T9_in, pad_S0_T10_in, pad_S0_T11_in,
                    pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in};
  assign side[1] = {pad_S1_T0_in, pad_S1_T1_in, pad_S1_T2_in, pad_S1_T3_in,
                    pad_S1_T4_in, pad_S1_T5_in, pad_S1_T6_in, pad_S1_T7_in,
                    pad_S1_T8_in, pad_S1_T9_in, pad_S1_T10_in, pad_S1_T11_in,
                    pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in};
  assign side[2] = {pad_S2_T0_in, pad_S2_T1_in, pad_S2_T2_in, pad_S2_T3_in,
                    pad_S2_T4_in, pad_S2_T5_in, pad_S2_T6_in, pad_S2_T7_in,
                    pad_S2_T8_in, pad_S2_T9_in, pad_S2_T10_in, pad_S2_T11_in,
                    pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in};
  assign side[3] = {pad_S3_T0_in, pad_S3_T1_in, pad_S3_T2_in, pad_S3_T3_in,
                    pad_S3_T4_in, pad_S3_T5_in, pad_S3_T6_in, pad_S3_T7_in,
                    pad_S3_T8_in, pad_S3_T9_in, pad_S3_T10_in, pad_S3_T11_in,
                    pad_S3_T12_in, pad_S3_T13_in, pad_S3_T14_in, pad_S3_T15_in};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      op_q    <= DEF_OP;
      srca_q  <= DEF_SRCA;
      srcb_q  <= DEF_SRCB;
      const_q <= DEF_CONST;
      oreg_q  <= DEF_OREG;
    end else begin
      case (config_addr_in)
        ADDR_OP:    op_q    <= config_data_in[3:0];
        ADDR_SRC: begin
          srca_q <= config_data_in[1:0];
          srcb_q <= config_data_in[4:2];
        end
        ADDR_CONST: const_q <= config_data_in[W-1:0];
        ADDR_OREG:  oreg_q  <= config_data_in[0];
        default:    ;
      endcase
    end
  end

  // SRCB values 4-7 all select the constant register.
  assign op_a = side[srca_q];
  assign op_b = srcb_q[2] ? const_q : side[srcb_q[1:0]];

  cgra_pe u_pe (
    .a   (op_a),
    .b   (op_b),
    .op  (op_q),
    .res (res)
  );

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) out_q <= '0;
    else           out_q <= res;
  end

  assign out_word = oreg_q ? out_q : res;

  assign {pad_S0_T0_out, pad_S0_T1_out, pad_S0_T2_out, pad_S0_T3_out,
          pad_S0_T4_out, pad_S0_T5_out, pad_S0_T6_out, pad_S0_T7_out,
          pad_S0_T8_out, pad_S0_T9_out, pad_S0_T10_out, pad_S0_T11_out,
          pad_S0_T12_out, pad_S0_T13_out, pad_S0_T14_out, pad_S0_T15_out} = out_word;

  // JTAG is reserved on this tile.
  assign tdo    = 1'b0;
  assign unused = ^{config_data_in[CFG_DW-1:W], tdi, tms, tck, trst_n};

endmodule

// File: tb/tb_cgra_top.sv
// Self-checking bench for cgra_top: power-up behaviour, opcode vectors, random model checks, reset and latency cases.
module tb_cgra_top;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic [31:0] config_addr_in = '0;
  logic [31:0] config_data_in = '0;
  logic [15:0] side [4];
  wire  [15:0] out_w;
  wire         tdo;
  logic        tdi = 1'b0, tms = 1'b0, tck = 1'b0, trst_n = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  initial for (int i = 0; i < 4; i++) side[i] = '0;

  cgra_top dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .config_addr_in(config_addr_in), .config_data_in(config_data_in),
    .pad_S0_T0_in(side[0][15]), .pad_S0_T1_in(side[0][14]), .pad_S0_T2_in(side[0][13]), .pad_S0_T3_in(side[0][12]),
    .pad_S0_T4_in(side[0][11]), .pad_S0_T5_in(side[0][10]), .pad_S0_T6_in(side[0][9]), .pad_S0_T7_in(side[0][8]),
    .pad_S0_T8_in(side[0][7]), .pad_S0_T9_in(side[0][6]), .pad_S0_T10_in(side[0][5]), .pad_S0_T11_in(side[0][4]),
    .pad_S0_T12_in(side[0][3]), .pad_S0_T13_in(side[0][2]), .pad_S0_T14_in(side[0][1]), .pad_S0_T15_in(side[0][0]),
    .pad_S1_T0_in(side[1][15]), .pad_S1_T1_in(side[1][14]), .pad_S1_T2_in(side[1][13]), .pad_S1_T3_in(side[1][12]),
    .pad_S1_T4_in(side[1][11]), .pad_S1_T5_in(side[1][10]), .pad_S1_T6_in(side[1][9]), .pad_S1_T7_in(side[1][8]),
    .pad_S1_T8_in(side[1][7]), .pad_S1_T9_in(side[1][6]), .pad_S1_T10_in(side[1][5]), .pad_S1_T11_in(side[1][4]),
    .pad_S1_T12_in(side[1][3]), .pad_S1_T13_in(side[1][2]), .pad_S1_T14_in(side[1][1]), .pad_S1_T15_in(side[1][0]),
    .pad_S2_T0_in(side[2][15]), .pad_S2_T1_in(side[2][14]), .pad_S2_T2_in(side[2][13]), .pad_S2_T3_in(side[2][12]),
    .pad_S2_T4_in(side[2][11]), .pad_S2_T5_in(side[2][10]), .pad_S2_T6_in(side[2][9]), .pad_S2_T7_in(side[2][8]),
    .pad_S2_T8_in(side[2][7]), .pad_S2_T9_in(side[2][6]), .pad_S2_T10_in(side[2][5]), .pad_S2_T11_in(side[2][4]),
    .pad_S2_T12_in(side[2][3]), .pad_S2_T13_in(side[2][2]), .pad_S2_T14_in(side[2][1]), .pad_S2_T15_in(side[2][0]),
    .pad_S3_T0_in(side[3][15]), .pad_S3_T1_in(side[3][14]), .pad_S3_T2_in(side[3][13]), .pad_S3_T3_in(side[3][12]),
    .pad_S3_T4_in(side[3][11]), .pad_S3_T5_in(side[3][10]), .pad_S3_T6_in(side[3][9]), .pad_S3_T7_in(side[3][8]),
    .pad_S3_T8_in(side[3][7]), .pad_S3_T9_in(side[3][6]), .pad_S3_T10_in(side[3][5]), .pad_S3_T11_in(side[3][4]),
    .pad_S3_T12_in(side[3][3]), .pad_S3_T13_in(side[3][2]), .pad_S3_T14_in(side[3][1]), .pad_S3_T15_in(side[3][0]),
    .pad_S0_T0_out(out_w[15]), .pad_S0_T1_out(out_w[14]), .pad_S0_T2_out(out_w[13]), .pad_S0_T3_out(out_w[12]),
    .pad_S0_T4_out(out_w[11]), .pad_S0_T5_out(out_w[10]), .pad_S0_T6_out(out_w[9]), .pad_S0_T7_out(out_w[8]),
    .pad_S0_T8_out(out_w[7]), .pad_S0_T9_out(out_w[6]), .pad_S0_T10_out(out_w[5]), .pad_S0_T11_out(out_w[4]),
    .pad_S0_T12_out(out_w[3]), .pad_S0_T13_out(out_w[2]), .pad_S0_T14_out(out_w[1]), .pad_S0_T15_out(out_w[0]),
    .tdi(tdi), .tms(tms), .tck(tck), .trst_n(trst_n), .tdo(tdo)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [1:0]  srca;
    logic [2:0]  srcb;
    logic [15:0] cnst;
    logic [15:0] s0, s1, s2, s3;
    logic [15:0] expected;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] expected);
    n_checks++;
    if (got !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, expected);
    end
  endtask

  task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk_in);
    config_addr_in = addr;
    config_data_in = data;
    @(posedge clk_in);
    #1;
    config_addr_in = '0;
    config_data_in = '0;
  endtask

  task automatic cfg_all(input logic [3:0] op, input logic [1:0] srca, input logic [2:0] srcb,
                         input logic [15:0] cnst);
    cfg_write(32'h1, {28'b0, op});
    cfg_write(32'h2, {27'b0, srcb, srca});
    cfg_write(32'h3, {16'b0, cnst});
  endtask

  task automatic pulse_reset();
    @(negedge clk_in);
    #2 reset_in = 1'b0;
    #2 reset_in = 1'b1;
  endtask

  // Reference: operand selection and arithmetic in plain integers, reduced mod 2^16 at the end.
  function automatic logic [15:0] ref_out(input int op, input int srca, input int srcb, input int cnst,
                                          input logic [15:0] s0, input logic [15:0] s1,
                                          input logic [15:0] s2, input logic [15:0] s3);
    longint w [4];
    longint a, b, r;
    w[0] = s0; w[1] = s1; w[2] = s2; w[3] = s3;
    a = w[srca];
    b = (srcb >= 4) ? longint'(cnst) : w[srcb];
    case (op)
      1:       r = a + b;
      2:       r = a - b + 65536;
      3:       r = a * b;
      4:       r = a * (longint'(1) << (b % 16));
      5:       r = a & b;
      6:       r = a | b;
      7:       r = a ^ b;
      default: r = a;
    endcase
    return 16'(r % 65536);
  endfunction

  initial begin
    logic [15:0] prev_exp;
    logic [15:0] r;
    int op, sa, sb, cn;

    vecs[0]  = '{"add",        4'd1,  2'd2, 3'd0, 16'h0000, 16'h0005, 16'h0000, 16'h0007, 16'h0000, 16'h000C};
    vecs[1]  = '{"sub_wrap",   4'd2,  2'd0, 3'd1, 16'h0000, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 16'hFFFE};
    vecs[2]  = '{"mul_low",    4'd3,  2'd1, 3'd3, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 16'h0010, 16'h2340};
    vecs[3]  = '{"shl_const",  4'd4,  2'd3, 3'd4, 16'h0013, 16'h0000, 16'h0000, 16'h0000, 16'h0F0F, 16'h7878};
    vecs[4]  = '{"and",        4'd5,  2'd0, 3'd1, 16'h0000, 16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 16'hF000};
    vecs[5]  = '{"or",         4'd6,  2'd0, 3'd1, 16'h0000, 16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 16'hFFF0};
    vecs[6]  = '{"xor",        4'd7,  2'd0, 3'd1, 16'h0000, 16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 16'h0FF0};
    vecs[7]  = '{"passa",      4'd0,  2'd1, 3'd0, 16'h0000, 16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 16'hFF00};
    vecs[8]  = '{"op12_passa", 4'd12, 2'd2, 3'd7, 16'h1111, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 16'hBEEF};
    vecs[9]  = '{"mul_const",  4'd3,  2'd2, 3'd5, 16'hFFFF, 16'h0000, 16'h0000, 16'h0003, 16'h0000, 16'hFFFD};
    vecs[10] = '{"shl_15",     4'd4,  2'd0, 3'd2, 16'h0000, 16'h0001, 16'h0000, 16'h001F, 16'h0000, 16'h8000};

    // Power-up defaults with no reset and no writes: out = 2 * S2.
    for (int i = 0; i <= 100; i++) begin
      @(posedge clk_in);
      #1 side[2] = 16'(i);
      @(negedge clk_in);
      check($sformatf("powerup_%0d", i), out_w, 16'((2 * i) % 65536));
    end
    check("tdo_low", {15'b0, tdo}, 16'h0000);

    side[2] = 16'h8001;
    #1 check("wrap_8001", out_w, 16'h0002);
    side[2] = 16'h8000;  // only pad S2 T0 high
    #1 check("t0_only_word", out_w, 16'h0000);
    check("t0_only_pad", {15'b0, out_w[15]}, 16'h0000);
    side[2] = 16'h4000;  // only pad S2 T1 high lands on out T0
    #1 check("t1_to_t0_pad", {15'b0, out_w[15]}, 16'h0001);

    // Address 0 and unmapped addresses leave the configuration alone.
    cfg_write(32'h0, 32'hFFFF_FFFF);
    cfg_write(32'h5, 32'hFFFF_FFFF);
    cfg_write(32'h8000_0001, 32'hFFFF_FFFF);
    side[0] = 16'hAAAA; side[2] = 16'h0123;
    #1 check("ignored_writes", out_w, 16'h0246);

    foreach (vecs[i]) begin
      cfg_all(vecs[i].op, vecs[i].srca, vecs[i].srcb, vecs[i].cnst);
      side[0] = vecs[i].s0; side[1] = vecs[i].s1; side[2] = vecs[i].s2; side[3] = vecs[i].s3;
      #1 check(vecs[i].name, out_w, vecs[i].expected);
    end

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 15); sa = $urandom_range(0, 3); sb = $urandom_range(0, 7);
      cn = $urandom_range(0, 65535);
      cfg_all(4'(op), 2'(sa), 3'(sb), 16'(cn));
      for (int k = 0; k < 4; k++) side[k] = 16'($urandom);
      #1 check($sformatf("rand_%0d_op%0d", i, op), out_w,
               ref_out(op, sa, sb, cn, side[0], side[1], side[2], side[3]));
    end

    // CONST written, then an asynchronous reset pulse restores the defaults.
    cfg_all(4'd3, 2'd2, 3'd4, 16'd10);
    side[2] = 16'd4;
    #1 check("const_10", out_w, 16'd40);
    pulse_reset();
    #1 check("const_after_reset", out_w, 16'd8);

    // Reset held across a config write: the write is lost.
    @(negedge clk_in);
    config_addr_in = 32'h1; config_data_in = 32'h1;
    reset_in = 1'b0;
    @(posedge clk_in);
    #1 config_addr_in = '0; config_data_in = '0;
    #1 reset_in = 1'b1;
    #1 check("reset_beats_write", out_w, 16'd8);

    // Back-to-back writes to the same address: the second one sticks.
    @(negedge clk_in);
    config_addr_in = 32'h1; config_data_in = 32'h5;
    @(posedge clk_in);
    #1 config_data_in = 32'h1;
    @(posedge clk_in);
    #1 config_addr_in = '0; config_data_in = '0;
    cfg_write(32'h2, {27'b0, 3'd0, 2'd2});
    side[0] = 16'd5; side[2] = 16'd7;
    #1 check("last_write_wins", out_w, 16'd12);

    // Registered output: one posedge of latency.
    pulse_reset();
    side[2] = 16'd1;
    cfg_write(32'h4, 32'h1);
    side[2] = 16'd3;
    #1 check("oreg_holds", out_w, 16'd2);
    @(negedge clk_in);
    check("oreg_holds_neg", out_w, 16'd2);
    @(posedge clk_in);
    #1 check("oreg_one_cycle", out_w, 16'd6);
    prev_exp = 16'd6;
    for (int i = 0; i < 8; i++) begin
      r = 16'($urandom);
      side[2] = r;
      @(negedge clk_in);
      check($sformatf("oreg_pipe_hold_%0d", i), out_w, prev_exp);
      @(posedge clk_in);
      #1 check($sformatf("oreg_pipe_%0d", i), out_w, 16'((32'(r) * 2) % 65536));
      prev_exp = 16'((32'(r) * 2) % 65536);
    end

    // Reset mid-cycle drops back to the combinational default path at once.
    side[2] = 16'd3;
    #1 reset_in = 1'b0;
    #1 check("reset_oreg_cleared", out_w, 16'd6);
    side[2] = 16'd21;
    #1 check("reset_comb_follow", out_w, 16'd42);
    reset_in = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
